// File: rtl/debounce_bank_pkg.sv
// rtl/debounce_bank_pkg.sv - shared constants and per-channel state encoding for debounce_bank
package debounce_bank_pkg;

    localparam int DEB_SYNC_STAGES   = 2;
    localparam int DEB_CNT_WIDTH     = 16;
    localparam int DEB_STABLE_CYCLES = 50000;

    typedef enum logic {
        DEB_IDLE    = 1'b0,
        DEB_PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: synchroniser, stability counter, filtered level and edge strobes
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEB_SYNC_STAGES,
    parameter int   CNT_WIDTH     = DEB_CNT_WIDTH,
    parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_next,
    output logic fall_next
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    deb_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_cur;
    logic                   level_d;
    logic                   accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    // The first mismatch edge already counts as a sample, so IDLE behaves as a zero count.
    assign cnt_cur = (state_q == DEB_IDLE) ? '0 : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        accept  = 1'b0;
        if (sync_q == level) begin
            state_d = DEB_IDLE;
            cnt_d   = '0;
        end else if (tick && (cnt_cur == LAST_COUNT)) begin
            accept  = 1'b1;
            level_d = sync_q;
            state_d = DEB_IDLE;
            cnt_d   = '0;
        end else begin
            state_d = DEB_PENDING;
            cnt_d   = tick ? (cnt_cur + CNT_WIDTH'(1)) : cnt_cur;
        end
    end

    assign rise_next = accept & sync_q;
    assign fall_next = accept & ~sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEB_IDLE;
            cnt_q   <= '0;
            level   <= RESET_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_next;
            fall    <= fall_next;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of independent debounced channels with a shared change indicator
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = DEB_SYNC_STAGES,
    parameter int   CNT_WIDTH     = DEB_CNT_WIDTH,
    parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_level,
    output logic [CHANNELS-1:0] sig_rise,
    output logic [CHANNELS-1:0] sig_fall,
    output logic                any_change
);

    logic [CHANNELS-1:0] rise_next;
    logic [CHANNELS-1:0] fall_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_WIDTH    (CNT_WIDTH),
            .STABLE_CYCLES(STABLE_CYCLES),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .sig_in   (sig_in[i]),
            .level    (sig_level[i]),
            .rise     (sig_rise[i]),
            .fall     (sig_fall[i]),
            .rise_next(rise_next[i]),
            .fall_next(fall_next[i])
        );
    end

    // Built from next-state strobes so it lines up with the registered strobe bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |(rise_next | fall_next);
        end
    end

endmodule
